// File: rtl/memory_responder.sv
// Slave end of the core's single-port memory bus: word RAM with byte-strobe writes,
// fixed wait states and sticky out-of-range flag. Optional: MEMORY_RESPONDER_IFETCH_FAST_EN.
`timescale 1ns/1ps
module memory_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        memory_error
);

  localparam int          IW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  localparam logic [3:0]  LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  count, next_count;
  logic        accept, enter_resp;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_wstrb;
  logic        lat_instr;
  logic [31:0] cur_addr, cur_wdata, offset;
  logic [3:0]  cur_wstrb;
  logic        in_range;
  logic [IW-1:0] index;
  logic [31:0] ram [DEPTH];
  logic        unused_bits;

  always_comb begin
    next_state = state;
    next_count = count;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (memory_valid) begin
          accept     = 1'b1;
          next_count = LOAD;
`ifdef MEMORY_RESPONDER_IFETCH_FAST_EN
          if (LATENCY == 1 || memory_instr) next_state = RESP;
          else                              next_state = WAIT;
`else
          if (LATENCY == 1) next_state = RESP;
          else              next_state = WAIT;
`endif
        end
      end
      WAIT: begin
        next_count = count - 4'd1;
        if (count <= 4'd1) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A zero-wait path goes IDLE->RESP in one edge, before the latches hold the
  // request, so the access uses the live bus fields in that case.
  assign cur_addr   = (state == IDLE) ? memory_addr  : lat_addr;
  assign cur_wdata  = (state == IDLE) ? memory_wdata : lat_wdata;
  assign cur_wstrb  = (state == IDLE) ? memory_wstrb : lat_wstrb;
  assign offset     = cur_addr - BASE_ADDR;
  assign in_range   = (offset < SPAN);
  assign index      = offset[IW+1:2];
  assign enter_resp = (next_state == RESP) && (state != RESP);

  assign memory_ready = (state == RESP);
  assign unused_bits  = ^{lat_instr, offset[1:0], memory_wdata[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= 4'd0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_wstrb    <= 4'd0;
      lat_instr    <= 1'b0;
      memory_rdata <= 32'd0;
      memory_error <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        lat_addr  <= memory_addr;
        lat_wdata <= memory_wdata;
        lat_wstrb <= memory_wstrb;
        lat_instr <= memory_instr;
      end
      if (enter_resp) begin
        if (in_range) begin
          memory_rdata <= ram[index];
        end else begin
          memory_rdata <= 32'd0;
          memory_error <= 1'b1;
        end
      end
    end
  end

  // RAM is never reset; the write lands on the same edge as the pre-write read.
  always_ff @(posedge clk) begin
    if (enter_resp && in_range && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstrb[i]) ram[index][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: vector table over a LATENCY=2 instance,
// plus back-to-back, reset-abort and LATENCY=4 fetch-timing sequences.
`timescale 1ns/1ps
module tb_memory_responder;

`ifdef MEMORY_RESPONDER_IFETCH_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid, instr;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        ready, error;

  logic        valid4, instr4;
  logic [31:0] addr4, wdata4, rdata4;
  logic [3:0]  wstrb4;
  logic        ready4, error4;

  int checks = 0;
  int passes = 0;

  memory_responder #(.DEPTH(16), .BASE_ADDR(32'h0), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .memory_valid(valid), .memory_instr(instr), .memory_addr(addr),
    .memory_wdata(wdata), .memory_wstrb(wstrb),
    .memory_rdata(rdata), .memory_ready(ready), .memory_error(error)
  );

  memory_responder #(.DEPTH(16), .BASE_ADDR(32'h0), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .memory_valid(valid4), .memory_instr(instr4), .memory_addr(addr4),
    .memory_wdata(wdata4), .memory_wstrb(wstrb4),
    .memory_rdata(rdata4), .memory_ready(ready4), .memory_error(error4)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver: one transaction on the LATENCY=2 instance; lat = negedges after acceptance
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins, output logic [31:0] rd, output int lat);
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; wstrb = s; instr = ins;
    @(posedge clk);
    #1;
    addr = ~a; wdata = ~d; wstrb = ~s; instr = ~ins;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
    end
    rd = rdata;
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic do_txn4(input logic ins, output int lat);
    @(negedge clk);
    valid4 = 1'b1; addr4 = 32'h0; wdata4 = 32'h0; wstrb4 = 4'h0; instr4 = ins;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready4) begin
        lat = k;
        break;
      end
    end
    valid4 = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [9:0]  mask;

    vecs[0]  = '{32'h00, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{32'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h04, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{32'h04, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11223344, 1'b0};
    vecs[4]  = '{32'h00, 32'hAABBCCDD, 4'h5, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{32'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEBBBEDD, 1'b0};
    vecs[6]  = '{32'h03, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEBBBEDD, 1'b0};
    vecs[7]  = '{32'h08, 32'h55667788, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{32'h3C, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{32'h3C, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0BADF00D, 1'b0};
    vecs[10] = '{32'h40, 32'h0,        4'h0, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[11] = '{32'h40, 32'h12345678, 4'hF, 1'b0, 1'b1, 32'h0,        1'b1};
    vecs[12] = '{32'h00, 32'h0,        4'h0, 1'b0, 1'b1, 32'hDEBBBEDD, 1'b1};
    vecs[13] = '{32'h08, 32'h0,        4'h0, 1'b1, 1'b1, 32'h55667788, 1'b1};

    rst = 1'b1;
    valid = 1'b0; instr = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
    valid4 = 1'b0; instr4 = 1'b0; addr4 = 32'h0; wdata4 = 32'h0; wstrb4 = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr, rd, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), (vecs[i].instr && FAST) ? 32'd1 : 32'd2);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
      @(negedge clk);
      check($sformatf("v%0d_ready_width", i), {31'd0, ready}, 32'd0);
    end

    // back-to-back: valid held across three reads
    @(negedge clk);
    valid = 1'b1; addr = 32'h4; wdata = 32'h0; wstrb = 4'h0; instr = 1'b0;
    @(posedge clk);
    mask = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      mask[k-1] = ready;
      if (ready) check($sformatf("b2b_rdata_k%0d", k), rdata, 32'h11223344);
      if (k == 8) valid = 1'b0;
    end
    check("b2b_pulse_mask", {22'd0, mask}, {22'd0, 10'b0010010010});

    // reset during WAIT of a write
    @(negedge clk);
    valid = 1'b1; addr = 32'h8; wdata = 32'hCAFEF00D; wstrb = 4'hF; instr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1; valid = 1'b0; wstrb = 4'h0;
    #1;
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_error", {31'd0, error}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b0;
    do_txn(32'h8, 32'h0, 4'h0, 1'b0, rd, lat);
    check("post_rst_latency", 32'(lat), 32'd2);
    check("post_rst_rdata", rd, 32'h55667788);
    check("post_rst_error", {31'd0, error}, 32'd0);

    // LATENCY=4 instance: fetch vs data timing
    do_txn4(1'b1, lat);
    check("lat4_instr", 32'(lat), FAST ? 32'd1 : 32'd4);
    @(negedge clk);
    check("lat4_instr_width", {31'd0, ready4}, 32'd0);
    do_txn4(1'b0, lat);
    check("lat4_data", 32'(lat), 32'd4);
    @(negedge clk);
    check("lat4_data_width", {31'd0, ready4}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
